// File: rtl/alu_seq.sv
// alu_seq: handshaked EX-stage ALU. Logic, add/sub, compares and shifts
// finish in one cycle. Multiply (shift-add) and divide (restoring) run
// iteratively, one bit per cycle, and return a HI/LO result pair.
module alu_seq #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             ovf,
    output logic             zero
);

    typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

    localparam logic [SHW-1:0] LAST_STEP = SHW'(WIDTH - 1);

    state_t               state;
    logic [SHW-1:0]       count;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     mag_b;
    logic [WIDTH-1:0]     a_q;
    logic                 is_div;
    logic                 neg_res;
    logic                 neg_rem;

    logic [WIDTH-1:0]     sum_add;
    logic [WIDTH-1:0]     sum_sub;
    logic [SHW-1:0]       shamt;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_ovf;

    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH-1:0]     div_diff;
    logic                 div_fits;
    logic [2*WIDTH-1:0]   div_next;

    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo;
    logic [WIDTH-1:0]     rem;

    // Absolute value for signed operands; unsigned operands pass through.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic take_abs);
        return (take_abs && v[WIDTH-1]) ? -v : v;
    endfunction

    assign sum_add = a + b;
    assign sum_sub = a - b;
    assign shamt   = b[SHW-1:0];

    // Single-cycle operations, evaluated directly from the request operands.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op)
            4'd0: alu_res = a & b;
            4'd1: alu_res = a | b;
            4'd2: alu_res = a ^ b;
            4'd3: alu_res = ~(a | b);
            4'd4: begin
                alu_res = sum_add;
                alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum_add[WIDTH-1] != a[WIDTH-1]);
            end
            4'd5: begin
                alu_res = sum_sub;
                alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sum_sub[WIDTH-1] != a[WIDTH-1]);
            end
            4'd6: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            4'd7: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            4'd8: alu_res = a << shamt;
            4'd9: alu_res = a >> shamt;
            4'd10: alu_res = $signed(a) >>> shamt;
            default: begin
                alu_res = '0;
                alu_ovf = 1'b0;
            end
        endcase
    end

    // One iteration step: shift-add for multiply, restore-subtract for divide.
    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mag_b & {WIDTH{acc[0]}}};
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_fits  = div_shift >= {1'b0, mag_b};
        div_diff  = div_shift[WIDTH-1:0] - mag_b;
        div_next  = div_fits ? {div_diff, acc[WIDTH-2:0], 1'b1}
                             : {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end

    // Sign correction applied once the magnitudes have been fully processed.
    always_comb begin
        prod_fix = neg_res ? -acc : acc;
        quo      = acc[WIDTH-1:0];
        rem      = acc[2*WIDTH-1:WIDTH];
    end

    assign zero = (result == '0);

    // Control FSM with registered handshake signals and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            hi        <= '0;
            ovf       <= 1'b0;
            count     <= '0;
            acc       <= '0;
            mag_b     <= '0;
            a_q       <= '0;
            is_div    <= 1'b0;
            neg_res   <= 1'b0;
            neg_rem   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        is_div   <= op[1];
                        in_ready <= 1'b0;
                        if (op[3:2] != 2'b11) begin
                            result    <= alu_res;
                            hi        <= '0;
                            ovf       <= alu_ovf;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            if (op[1]) begin
                                acc   <= {{WIDTH{1'b0}}, magnitude(a, op[0])};
                                mag_b <= magnitude(b, op[0]);
                            end else begin
                                acc   <= {{WIDTH{1'b0}}, magnitude(b, op[0])};
                                mag_b <= magnitude(a, op[0]);
                            end
                            neg_res <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_rem <= op[0] & a[WIDTH-1];
                            count   <= '0;
                            state   <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    acc   <= is_div ? div_next : mul_next;
                    count <= count + 1'b1;
                    if (count == LAST_STEP) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    ovf <= 1'b0;
                    if (is_div) begin
                        if (mag_b == '0) begin
                            result <= '1;
                            hi     <= a_q;
                        end else begin
                            result <= neg_res ? -quo : quo;
                            hi     <= neg_rem ? -rem : rem;
                        end
                    end else begin
                        {hi, result} <= prod_fix;
                    end
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq. Accepted requests push a
// reference result; the monitor pops and compares it at the result handshake.
module tb_alu_seq;

    typedef struct {
        logic [31:0] res;
        logic [31:0] hi;
        logic        ovf;
        logic        zero;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, ovf, zero;
    logic [3:0]  op;
    logic [31:0] a, b, result, hi;

    logic        in_valid8, in_ready8, out_valid8, ovf8, zero8;
    logic [3:0]  op8;
    logic [7:0]  a8, b8, result8, hi8;

    int checks = 0;
    int errors = 0;

    exp_t        sb[$];
    bit          pending = 1'b0;
    bit          prev_valid = 1'b0;
    int          cyc = 0;
    int          acc_edge = 0;
    int          hs_edge = 0;
    int          acc_count = 0;
    logic [31:0] held_res, held_hi;
    logic        held_ovf, held_zero;

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .hi(hi), .ovf(ovf), .zero(zero)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .op(op8), .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(1'b1),
        .result(result8), .hi(hi8), .ovf(ovf8), .zero(zero8)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, expv);
        end
    endtask

    // Reference model for WIDTH=32 built on native wide arithmetic.
    function automatic exp_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        logic [63:0] p;
        longint      sx, sy, q, r;
        e.res = '0; e.hi = '0; e.ovf = 1'b0; e.lat = 1;
        sx = $signed(x);
        sy = $signed(y);
        case (o)
            4'd0: e.res = x & y;
            4'd1: e.res = x | y;
            4'd2: e.res = x ^ y;
            4'd3: e.res = ~(x | y);
            4'd4: begin e.res = x + y; e.ovf = (x[31] == y[31]) && (e.res[31] != x[31]); end
            4'd5: begin e.res = x - y; e.ovf = (x[31] != y[31]) && (e.res[31] != x[31]); end
            4'd6: e.res = (sx < sy) ? 32'd1 : 32'd0;
            4'd7: e.res = (x < y) ? 32'd1 : 32'd0;
            4'd8: e.res = x << y[4:0];
            4'd9: e.res = x >> y[4:0];
            4'd10: e.res = $signed(x) >>> y[4:0];
            4'd12: begin p = {32'd0, x} * {32'd0, y}; e.hi = p[63:32]; e.res = p[31:0]; end
            4'd13: begin p = sx * sy; e.hi = p[63:32]; e.res = p[31:0]; end
            4'd14, 4'd15: begin
                if (y == 32'd0) begin
                    e.res = 32'hFFFF_FFFF; e.hi = x;
                end else if (o == 4'd14) begin
                    e.res = x / y; e.hi = x % y;
                end else begin
                    q = sx / sy; r = sx % sy;
                    e.res = 32'(q); e.hi = 32'(r);
                end
            end
            default: e.res = '0;
        endcase
        if (o >= 4'd12) e.lat = 34;
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    // Cycle counter; index of the most recent rising edge.
    always @(posedge clk) cyc++;

    // Monitor: samples mid-cycle, checks handshake rules, pushes/pops the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst_n) begin
            sb.delete();
            pending = 1'b0;
            prev_valid = 1'b0;
        end else begin
            checkOutput("in_ready", in_ready, !pending);
            if (!pending) checkOutput("out_valid_idle", out_valid, 1'b0);
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("sb_size", sb.size(), 1);
                end else begin
                    if (!prev_valid) begin
                        checkOutput("latency", (cyc + 1) - acc_edge, sb[0].lat);
                    end else begin
                        checkOutput("hold_result", result, held_res);
                        checkOutput("hold_hi", hi, held_hi);
                        checkOutput("hold_ovf", ovf, held_ovf);
                        checkOutput("hold_zero", zero, held_zero);
                    end
                    if (out_ready) begin
                        e = sb.pop_front();
                        checkOutput("result", result, e.res);
                        checkOutput("hi", hi, e.hi);
                        checkOutput("ovf", ovf, e.ovf);
                        checkOutput("zero", zero, e.zero);
                        pending = 1'b0;
                        hs_edge = cyc + 1;
                    end
                end
            end
            prev_valid = out_valid;
            held_res = result; held_hi = hi; held_ovf = ovf; held_zero = zero;
            if (in_valid && in_ready) begin
                sb.push_back(model(op, a, b));
                pending = 1'b1;
                acc_edge = cyc + 1;
                acc_count++;
            end
        end
    end

    // Drive one request from a falling edge and hold it until accepted.
    task automatic applyStimulus(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        int c0;
        int n;
        c0 = acc_count;
        n = 0;
        in_valid = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        while (acc_count == c0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (acc_count == c0) checkOutput("accept_timeout", n, 0);
        in_valid = 1'b0;
        op = 4'($urandom); a = $urandom; b = $urandom;
    endtask

    // Wait until the scoreboard drains, bounded.
    task automatic waitDone();
        int n;
        n = 0;
        while ((pending || sb.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (pending) checkOutput("done_timeout", pending, 1'b0);
    endtask

    // WIDTH=8 instance: one request, measure latency and compare the result pair.
    task automatic runW8(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] er, input logic [7:0] eh);
        int lat;
        lat = 0;
        checkOutput("w8_in_ready", in_ready8, 1'b1);
        in_valid8 = 1'b1; op8 = o; a8 = x; b8 = y;
        @(negedge clk);
        in_valid8 = 1'b0; a8 = 8'h5A; b8 = 8'hA5;
        for (int k = 1; k <= 40; k++) begin
            #2;
            if (out_valid8) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        checkOutput("w8_latency", lat, 10);
        checkOutput("w8_result", result8, er);
        checkOutput("w8_hi", hi8, eh);
        @(negedge clk);
    endtask

    // Global watchdog.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

    // Main test sequence.
    initial begin
        int c0;
        int first_acc;
        rst_n = 1'b0; out_ready = 1'b1;
        in_valid = 1'b0; op = '0; a = '0; b = '0;
        in_valid8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_result", result, 0);
        checkOutput("rst_hi", hi, 0);
        checkOutput("rst_ovf", ovf, 0);
        checkOutput("rst_zero", zero, 1);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst8_zero", zero8, 1);
        checkOutput("rst8_out_valid", out_valid8, 0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] directed single-cycle ops");
        applyStimulus(4'd4, 32'h7FFF_FFFF, 32'd1);  waitDone();
        applyStimulus(4'd5, 32'd5, 32'd5);          waitDone();
        applyStimulus(4'd6, 32'hFFFF_FFFF, 32'd1);  waitDone();
        applyStimulus(4'd7, 32'hFFFF_FFFF, 32'd1);  waitDone();
        applyStimulus(4'd10, 32'h8000_0000, 32'd4); waitDone();
        applyStimulus(4'd11, 32'h1234_5678, 32'h9); waitDone();
        applyStimulus(4'd5, 32'h8000_0000, 32'd1);  waitDone();
        applyStimulus(4'd3, 32'h0F0F_0000, 32'h00F0_00FF); waitDone();
        applyStimulus(4'd8, 32'h0000_0003, 32'h0000_0021); waitDone();

        $display("[TB] back-to-back throughput");
        applyStimulus(4'd0, 32'hFF00_FF00, 32'h0FF0_0FF0);
        first_acc = acc_edge;
        applyStimulus(4'd1, 32'hFF00_FF00, 32'h0FF0_0FF0);
        checkOutput("throughput", acc_edge - first_acc, 2);
        waitDone();

        $display("[TB] directed multiply/divide");
        applyStimulus(4'd13, 32'hFFFF_FFFD, 32'd7);         waitDone();
        applyStimulus(4'd15, 32'hFFFF_FFF9, 32'd2);         waitDone();
        applyStimulus(4'd14, 32'd100, 32'd0);               waitDone();
        applyStimulus(4'd15, 32'h8000_0000, 32'hFFFF_FFFF); waitDone();
        applyStimulus(4'd15, 32'hFFFF_FFF9, 32'd0);         waitDone();
        applyStimulus(4'd13, 32'h8000_0000, 32'h8000_0000); waitDone();

        $display("[TB] random ops");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(4'($urandom_range(0, 11)), $urandom, $urandom);
            waitDone();
        end
        for (int i = 0; i < 8; i++) begin
            applyStimulus(4'(12 + (i % 4)), $urandom, (i < 4) ? $urandom : 32'($urandom_range(1, 300)));
            waitDone();
        end

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        c0 = acc_count;
        in_valid = 1'b1; op = 4'd4; a = 32'd2; b = 32'd3;
        repeat (44) @(negedge clk);
        checkOutput("ignored_while_busy", acc_count, c0);
        out_ready = 1'b1;
        for (int n = 0; n < 20 && acc_count == c0; n++) @(negedge clk);
        in_valid = 1'b0;
        checkOutput("accept_first_ready", acc_edge, hs_edge + 1);
        waitDone();

        $display("[TB] reset during divide");
        applyStimulus(4'd13, 32'hFFFF_FFFD, 32'd7); waitDone();
        applyStimulus(4'd14, 32'd1000, 32'd7);
        repeat (9) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("arst_result", result, 0);
        checkOutput("arst_hi", hi, 0);
        checkOutput("arst_ovf", ovf, 0);
        checkOutput("arst_zero", zero, 1);
        checkOutput("arst_out_valid", out_valid, 0);
        checkOutput("arst_in_ready", in_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        applyStimulus(4'd14, 32'd1000, 32'd7); waitDone();

        $display("[TB] WIDTH=8 instance");
        runW8(4'd13, 8'hFD, 8'd7, 8'hEB, 8'hFF);
        runW8(4'd15, 8'hF9, 8'd2, 8'hFD, 8'hFF);
        runW8(4'd14, 8'd100, 8'd0, 8'hFF, 8'd100);
        runW8(4'd12, 8'hFF, 8'hFF, 8'h01, 8'hFE);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the datapath ALU.
- Executes the full MIPS integer operation set on WIDTH-bit operands.
- Covers logic, add/sub with overflow, set-less-than and shifts in one cycle.
- Adds iterative signed/unsigned multiply (shift-add) and divide (restoring), with a HI/LO result pair.
- Sits in the EX stage behind a valid/ready handshake so the pipeline can stall while a multi-cycle operation runs.

## Interface
Parameters:
- WIDTH, 32, operand/result width; must be ≥4 and a power of two.
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request.
- op  in  4  operation code (see Operation).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result registers hold a valid result.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  primary result (LO for multiply/divide).
- hi  out  WIDTH  HI: product upper half or remainder; 0 for single-cycle ops.
- ovf  out  1  signed overflow for ADD/SUB; 0 otherwise.
- zero  out  1  result == 0.

## Operation
- Op codes:
  - 0 AND, 1 OR, 2 XOR, 3 NOR.
  - 4 ADD, 5 SUB.
  - 6 SLT (signed, result 1/0), 7 SLTU.
  - 8 SLL (a << b[SHW-1:0]), 9 SRL, 10 SRA.
  - 11 reserved: result 0, hi 0, ovf 0.
  - 12 MULTU, 13 MULT, 14 DIVU, 15 DIV.
- States: IDLE, BUSY, FIX, DONE.
- IDLE: in_ready=1. When in_valid=1:
  - Latch op, a and b.
  - Ops 0–11: compute and load the output registers, go to DONE.
  - Ops 12–15: latch operand magnitudes (signed ops take absolute values and record the sign of the result), clear the counter, go to BUSY.
- BUSY: one shift-add or restore-subtract step per cycle. Counter runs 0..WIDTH-1; after step WIDTH-1, go to FIX.
- FIX: apply sign correction.
  - MULT: negate the 2·WIDTH product if the operand signs differ.
  - DIV: quotient is negated if the signs differ; remainder takes the sign of a.
  - Load hi/result, go to DONE.
- DONE: out_valid=1. Outputs are held stable until out_ready=1, then go to IDLE.
- in_ready is 1 only in IDLE. No request overlaps a pending result.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - ovf=1 when operand signs (after B inversion for SUB) match and the result sign differs.
  - Multiply: {hi,result} is the exact 2·WIDTH product.
- Divide by zero (b=0): result = all ones, hi = a, for both DIV and DIVU.
- DIV of most-negative by -1: result = most-negative, hi = 0.
- zero is computed from the value loaded into result.

## Timing
- Reset (rst_n=0, any state, including mid-BUSY):
  - State → IDLE, in_ready=1, out_valid=0.
  - result, hi, ovf and the counter are cleared to 0; zero reads 1.
  - The in-flight operation is discarded with no output.
- Single-cycle op accepted at edge t → out_valid=1 after edge t+1.
- Multiply/divide accepted at edge t:
  - BUSY for WIDTH cycles, then FIX for 1 cycle.
  - out_valid=1 after edge t+WIDTH+2 (t+34 for WIDTH=32).
- Result handshake completes on an edge with out_valid=1 and out_ready=1. in_ready rises on the following cycle.
- Peak throughput: one single-cycle op per 2 cycles.
- out_ready held low: state stays DONE, and result, hi, ovf and zero do not change.
- in_valid while in_ready=0 is ignored. op, a and b changes have no effect after acceptance.

## Test plan
- WIDTH=32, ADD a=0x7FFFFFFF b=1 → result 0x80000000, ovf=1, zero=0, out_valid one cycle after accept. SUB 5−5 → result 0, zero=1, ovf=0.
- SLT a=0xFFFFFFFF b=1 → 1; SLTU same operands → 0. SRA a=0x80000000 b=4 → 0xF8000000. Op 11 → all outputs 0.
- MULT a=−3 (0xFFFFFFFD) b=7 → hi=0xFFFFFFFF, result=0xFFFFFFEB. out_valid exactly 34 cycles after accept; in_ready=0 throughout.
- DIV a=−7 b=2 → result 0xFFFFFFFD (−3), hi 0xFFFFFFFF (−1). DIVU a=100 b=0 → result 0xFFFFFFFF, hi 100. DIV 0x80000000 by −1 → result 0x80000000, hi 0.
- Backpressure: out_ready low for 10 cycles after MULTU 0xFFFFFFFF×0xFFFFFFFF → outputs stable at hi=0xFFFFFFFE, result=1. A new in_valid is ignored until the handshake, and accepted on the first cycle in_ready=1.
- Assert rst_n=0 at BUSY cycle 10 of a DIVU → outputs cleared immediately (asynchronous), out_valid never rises for that op. Reissue after reset → correct result at the standard latency. Repeat with WIDTH=8 to check the parametrised latency (10 cycles).
